// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the sequential ALU.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, MSB-first: one partial-product step per clock, WIDTH steps total.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Horner form: acc = acc*2 + a*b[i], walking b from its MSB down.
    assign w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0}
                      + (r_b[r_cnt] ? {{WIDTH{1'b0}}, r_a} : {(2*WIDTH){1'b0}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(WIDTH - 1);
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

    // High during the final step, so the product is complete on the following cycle.
    assign o_done    = r_busy && (r_cnt == '0);
    assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready-handshaked ALU with status flags and an optional multi-cycle multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam bit MUL_ON = (MUL_EN != 0);

    state_e             r_state;
    state_e             w_state_next;
    logic               r_init;
    logic               r_is_mul;
    logic               r_err;
    logic               r_z;
    logic               r_n;
    logic               r_c;
    logic               r_v;
    logic [WIDTH-1:0]   r_res;

    op_e                w_op;
    logic               w_is_mul;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_sh;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_arith;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_err;

    assign w_op     = op_e'(op);
    assign w_is_mul = (w_op == OP_MUL) && MUL_ON;
    assign w_sh     = WIDTH'(32'(b) % WIDTH);
    // One guard bit on each side catches the last bit shifted out.
    assign w_shl    = {1'b0, a} << w_sh;
    assign w_shr    = {a, 1'b0} >> w_sh;

    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_err   = 1'b0;
        w_arith = '0;
        unique case (w_op)
            OP_ADD: begin
                w_arith = {1'b0, a} + {1'b0, b};
                w_res   = w_arith[WIDTH-1:0];
                w_c     = w_arith[WIDTH];
                w_v     = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_arith = {1'b0, a} - {1'b0, b};
                w_res   = w_arith[WIDTH-1:0];
                w_c     = w_arith[WIDTH];
                w_v     = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_MUL: w_err = !MUL_ON;
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_mul_start  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid && r_init) begin
                    w_accept    = 1'b1;
                    w_mul_start = w_is_mul;
                    if (w_is_mul) begin
                        w_state_next = BUSY;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            BUSY: begin
                if (w_mul_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_init   <= 1'b0;
            r_is_mul <= 1'b0;
            r_err    <= 1'b0;
            r_res    <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_init  <= 1'b1;
            if (w_accept) begin
                r_is_mul <= w_is_mul;
                r_err    <= w_err;
                r_res    <= w_res;
                r_z      <= !w_err && (w_res == '0);
                r_n      <= w_res[WIDTH-1];
                r_c      <= w_c;
                r_v      <= w_v;
            end
        end
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );

    assign in_ready = r_init && (r_state == IDLE);

    // The multiplier sits idle in DONE, so its product register holds steady under backpressure.
    always_comb begin
        out_valid  = (r_state == DONE);
        alu_out    = '0;
        alu_out_hi = '0;
        flag_z     = 1'b0;
        flag_n     = 1'b0;
        flag_c     = 1'b0;
        flag_v     = 1'b0;
        err        = 1'b0;
        if (out_valid) begin
            if (r_is_mul) begin
                alu_out    = w_prod[WIDTH-1:0];
                alu_out_hi = w_prod[2*WIDTH-1:WIDTH];
                flag_z     = (w_prod == '0);
                flag_n     = w_prod[WIDTH-1];
                flag_c     = (w_prod[2*WIDTH-1:WIDTH] != '0);
            end else begin
                alu_out = r_res;
                flag_z  = r_z;
                flag_n  = r_n;
                flag_c  = r_c;
                flag_v  = r_v;
                err     = r_err;
            end
        end
    end

endmodule
